imem_load_arb: RTL and testbench

Parametrised single-port instruction-memory front end for the MemSoC. It replaces the fixed init-enable wiring between controller and SRAM macro: a streaming loader writes a burst of words (valid/ready, auto-incrementing address, wrap-around) while the core is held off, and the core gets a pipelined read port with registered data and a valid strobe. It sits between the controller, the external init interface and one OpenRAM-style 1rw port (active-low `csb`/`web`, one-cycle read latency).

---
 rtl/vsdmem_pkg.sv | 15 +
 rtl/imem_load_seq.sv | 42 ++++
 rtl/imem_load_arb.sv | 141 ++++++++++++++
 tb/tb_imem_load_arb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsdmem_pkg.sv
// Shared types and constants for the instruction-memory front end.
// FSM state encoding, read latency and SRAM port idle levels.
package vsdmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH
  } ld_state_e;

  localparam int   RD_LAT   = 2;
  localparam logic CSB_IDLE = 1'b1;
  localparam logic WEB_READ = 1'b1;

endpackage

// File: rtl/imem_load_seq.sv
// Burst sequencer: write address register, saturating word counter, last-beat flag.
// Ports: start/base/len latch a burst, beat advances it, addr/last report position.
module imem_load_seq #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              beat,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   len_sat;

  // A burst longer than the memory would rewrite words, so cap it.
  assign len_sat = (len > DEPTH) ? DEPTH : len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      addr_q <= base;
      cnt_q  <= len_sat;
    end else if (beat) begin
      addr_q <= addr_q + ADDR_W'(1);
      cnt_q  <= cnt_q - ONE;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == ONE);

endmodule

// File: rtl/imem_load_arb.sv
// Instruction-memory front end: streaming loader vs. pipelined core reads on one 1rw SRAM.
// Ports: load_* / ld_* loader, core_* read port, mem_* SRAM port 0, CLK / reset_n.
module imem_load_arb
  import vsdmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int MASK_W = DATA_W/8
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              load_busy,
  output logic              load_done,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_ready,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  ld_state_e state_q, state_d;

  logic              seq_start;
  logic              seq_beat;
  logic              seq_last;
  logic [ADDR_W-1:0] seq_addr;
  logic              zlen;
  logic              zdone_q;
  logic              accept;
  logic              rd_s1_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  imem_load_seq #(
    .ADDR_W(ADDR_W)
  ) u_seq (
    .clk  (CLK),
    .rst_n(reset_n),
    .start(seq_start),
    .base (load_base),
    .len  (load_len),
    .beat (seq_beat),
    .addr (seq_addr),
    .last (seq_last)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Everything combinational is gated by reset_n so that the
  // port sits at its reset levels while reset is held.
  always_comb begin
    state_d    = state_q;
    ld_ready   = 1'b0;
    core_ready = 1'b0;
    mem_csb    = CSB_IDLE;
    mem_web    = WEB_READ;
    mem_wmask  = '0;
    mem_addr   = '0;
    mem_din    = '0;
    seq_start  = 1'b0;
    seq_beat   = 1'b0;
    zlen       = 1'b0;
    if (reset_n) begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          core_ready = 1'b1;
          if (core_req) begin
            mem_csb  = 1'b0;
            mem_addr = core_addr;
          end
          if (load_start) begin
            if (load_len != '0) begin
              seq_start = 1'b1;
              state_d   = S_LOAD;
            end else begin
              zlen = 1'b1;
            end
          end
        end
        (state_q == S_LOAD): begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            seq_beat  = 1'b1;
            mem_csb   = 1'b0;
            mem_web   = 1'b0;
            mem_wmask = '1;
            mem_din   = ld_data;
            mem_addr  = seq_addr;
            if (seq_last) state_d = S_FLUSH;
          end
        end
        (state_q == S_FLUSH): begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign accept = core_req & core_ready;

  // Stage 1 waits for the macro, stage 2 registers its output.
  // Capture happens before any write in the following cycle
  // can disturb mem_dout.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rd_s1_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      zdone_q  <= 1'b0;
    end else begin
      rd_s1_q  <= accept;
      rvalid_q <= rd_s1_q;
      zdone_q  <= zlen;
      if (rd_s1_q) rdata_q <= mem_dout;
    end
  end

  assign core_rvalid = rvalid_q;
  assign core_rdata  = rdata_q;
  assign load_busy   = (state_q != S_IDLE);
  assign load_done   = (state_q == S_FLUSH) | zdone_q;

endmodule

// File: tb/tb_imem_load_arb.sv
// Self-checking bench for imem_load_arb with a behavioural SRAM macro.
// Expected writes / reads are queued from burst arithmetic and a shadow memory.
module tb_imem_load_arb;
  import vsdmem_pkg::*;

  logic        CLK;
  logic        reset_n;
  logic        load_start;
  logic [7:0]  load_base;
  logic [8:0]  load_len;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        load_busy;
  logic        load_done;
  logic        core_req;
  logic [7:0]  core_addr;
  logic        core_ready;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        mem_csb;
  logic        mem_web;
  logic [3:0]  mem_wmask;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  imem_load_arb #(.ADDR_W(8), .DATA_W(32)) dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_ready (core_ready),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .mem_csb    (mem_csb),
    .mem_web    (mem_web),
    .mem_wmask  (mem_wmask),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] sram [256];
  logic [31:0] ref_mem [256];
  logic [31:0] nw;

  always @(posedge CLK) begin
    if (!mem_csb) begin
      if (!mem_web) begin
        nw = sram[mem_addr];
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) nw[b*8 +: 8] = mem_din[b*8 +: 8];
        sram[mem_addr] <= nw;
      end else begin
        mem_dout <= sram[mem_addr];
      end
    end
  end

  function automatic logic [31:0] pre(input int i);
    return 32'hA500_0000 ^ (i * 32'h0101_0101);
  endfunction

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int cyc   = 0;
  bit chk_en = 0;
  bit exp_idle = 1;
  bit exp_busy = 0;
  bit exp_done = 0;

  task automatic cmp(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge CLK) cyc++;

  // Scoreboard: handshake levels, write stream order, read responses.
  always @(negedge CLK) begin
    if (chk_en) begin
      wr_t w;
      rd_t r;
      cmp("core_ready", 64'(core_ready), 64'(exp_idle));
      cmp("ld_ready", 64'(ld_ready), 64'(exp_busy && !exp_done));
      cmp("load_busy", 64'(load_busy), 64'(exp_busy));
      cmp("load_done", 64'(load_done), 64'(exp_done));
      if (!mem_csb && !mem_web) begin
        n_wr++;
        if (wq.size() == 0) begin
          cmp("stray_write", 64'(mem_addr), 64'hFFFF);
        end else begin
          w = wq.pop_front();
          cmp("wr_addr", 64'(mem_addr), 64'(w.a));
          cmp("wr_data", 64'(mem_din), 64'(w.d));
          cmp("wr_mask", 64'(mem_wmask), 64'hF);
          ref_mem[w.a] = w.d;
        end
      end
      if (core_rvalid) begin
        if (rq.size() == 0) begin
          cmp("stray_rvalid", 64'(core_rdata), 64'hFFFF_FFFF_0);
        end else begin
          r = rq.pop_front();
          cmp("rdata", 64'(core_rdata), 64'(r.d));
          cmp("rd_latency", 64'(cyc), 64'(r.due));
        end
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        cmp("rvalid_missing", 64'(0), 64'(1));
      end
      if (core_req && exp_idle) begin
        cmp("rd_csb", 64'(mem_csb), 64'(0));
        cmp("rd_web", 64'(mem_web), 64'(1));
        cmp("rd_addr", 64'(mem_addr), 64'(core_addr));
        rq.push_back('{due: cyc + RD_LAT, d: ref_mem[core_addr]});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [7:0] a);
    core_req  = 1'b1;
    core_addr = a;
    step();
    core_req  = 1'b0;
  endtask

  task automatic load_burst(input logic [7:0] base, input logic [8:0] len,
                            input bit gap, input bit with_rd,
                            input logic [7:0] raddr);
    int n;
    logic [31:0] d[$];
    n = (len > 9'd256) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      d.push_back($urandom);
      wq.push_back('{a: base + 8'(i), d: d[i]});
    end
    load_start = 1'b1;
    load_base  = base;
    load_len   = len;
    core_req   = with_rd;
    core_addr  = raddr;
    step();
    load_start = 1'b0;
    core_req   = 1'b0;
    if (n == 0) begin
      exp_done = 1;
      step();
      exp_done = 0;
      return;
    end
    exp_idle = 0;
    exp_busy = 1;
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        ld_valid = 1'b0;
        step();
      end
      ld_valid = 1'b1;
      ld_data  = d[i];
      step();
    end
    ld_valid = 1'b0;
    exp_done = 1;
    step();
    exp_done = 0;
    exp_busy = 0;
    exp_idle = 1;
    cmp("writes_left", 64'(wq.size()), 64'(0));
  endtask

  typedef struct {
    logic        rst;
    logic        req;
    logic [7:0]  addr;
    logic        e_csb;
    logic        e_rdy;
    logic        e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int w0;
    logic [31:0] d6[6];

    for (int i = 0; i < 256; i++) begin
      sram[i]    = pre(i);
      ref_mem[i] = pre(i);
    end
    mem_dout   = '0;
    reset_n    = 1'b1;
    load_start = 1'b0;
    load_base  = '0;
    load_len   = '0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    core_req   = 1'b0;
    core_addr  = '0;

    tv.push_back('{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 32'h0});
    tv.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0});
    tv.push_back('{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0});
    tv.push_back('{1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 32'h0});
    tv.push_back('{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0});
    tv.push_back('{1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, pre(8'h10)});
    tv.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, pre(8'h11)});
    tv.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, pre(8'hFF)});
    tv.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0});

    #1;
    for (int i = 0; i < tv.size(); i++) begin
      reset_n   = tv[i].rst;
      core_req  = tv[i].req;
      core_addr = tv[i].addr;
      @(negedge CLK);
      cmp($sformatf("tv%0d_csb", i), 64'(mem_csb), 64'(tv[i].e_csb));
      cmp($sformatf("tv%0d_web", i), 64'(mem_web), 64'(1));
      cmp($sformatf("tv%0d_rdy", i), 64'(core_ready), 64'(tv[i].e_rdy));
      cmp($sformatf("tv%0d_rv", i), 64'(core_rvalid), 64'(tv[i].e_rv));
      cmp($sformatf("tv%0d_ldr", i), 64'(ld_ready), 64'(0));
      if (!tv[i].e_csb || !tv[i].rst)
        cmp($sformatf("tv%0d_addr", i), 64'(mem_addr),
            64'(tv[i].rst ? tv[i].addr : 8'h00));
      if (!tv[i].rst)
        cmp($sformatf("tv%0d_rdata", i), 64'(core_rdata), 64'(0));
      if (tv[i].e_rv)
        cmp($sformatf("tv%0d_rdata", i), 64'(core_rdata), 64'(tv[i].e_rd));
      @(posedge CLK);
      #1;
    end
    core_req = 1'b0;
    chk_en   = 1;

    // back-to-back reads of preloaded words
    for (int i = 0; i < 4; i++) rd(8'(i));
    repeat (3) step();

    // wrapping burst, continuous valid
    load_burst(8'hFE, 9'd4, 1'b0, 1'b0, 8'h00);
    rd(8'hFE); rd(8'hFF); rd(8'h00); rd(8'h01);
    repeat (3) step();

    // same burst, valid gapped
    load_burst(8'hFE, 9'd4, 1'b1, 1'b0, 8'h00);
    rd(8'hFE); rd(8'hFF); rd(8'h00); rd(8'h01);
    repeat (3) step();

    // read accepted in the load_start cycle, then overwritten
    load_burst(8'h05, 9'd3, 1'b0, 1'b1, 8'h05);
    rd(8'h05);
    repeat (3) step();

    // zero-length burst
    w0 = n_wr;
    load_burst(8'h40, 9'd0, 1'b0, 1'b0, 8'h00);
    step();
    cmp("len0_writes", 64'(n_wr - w0), 64'(0));

    // oversized burst saturates to the full depth
    w0 = n_wr;
    load_burst(8'h80, 9'h1FF, 1'b0, 1'b0, 8'h00);
    cmp("sat_writes", 64'(n_wr - w0), 64'(256));
    rd(8'h7F); rd(8'h80);
    repeat (3) step();

    // reset after 2 of 6 beats
    b = 8'h20;
    for (int i = 0; i < 6; i++) d6[i] = $urandom;
    for (int i = 0; i < 6; i++) wq.push_back('{a: b + 8'(i), d: d6[i]});
    load_start = 1'b1;
    load_base  = b;
    load_len   = 9'd6;
    step();
    load_start = 1'b0;
    exp_idle   = 0;
    exp_busy   = 1;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = d6[i];
      step();
    end
    ld_data = d6[2];
    chk_en  = 0;
    reset_n = 1'b0;
    #1;
    cmp("rst_ld_ready", 64'(ld_ready), 64'(0));
    cmp("rst_busy", 64'(load_busy), 64'(0));
    cmp("rst_done", 64'(load_done), 64'(0));
    cmp("rst_core_ready", 64'(core_ready), 64'(0));
    cmp("rst_rvalid", 64'(core_rvalid), 64'(0));
    cmp("rst_rdata", 64'(core_rdata), 64'(0));
    cmp("rst_csb", 64'(mem_csb), 64'(1));
    cmp("rst_web", 64'(mem_web), 64'(1));
    cmp("rst_wmask", 64'(mem_wmask), 64'(0));
    cmp("rst_addr", 64'(mem_addr), 64'(0));
    cmp("rst_din", 64'(mem_din), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      cmp("rst_no_done", 64'(load_done), 64'(0));
    end
    cmp("rst_kept0", 64'(sram[b]), 64'(d6[0]));
    cmp("rst_kept1", 64'(sram[b + 8'd1]), 64'(d6[1]));
    cmp("rst_untouched", 64'(sram[b + 8'd2]), 64'(ref_mem[b + 8'd2]));
    wq.delete();
    rq.delete();
    ld_valid = 1'b0;
    @(posedge CLK);
    #1;
    reset_n  = 1'b1;
    exp_busy = 0;
    exp_idle = 1;
    chk_en   = 1;
    rd(b); rd(b + 8'd1); rd(b + 8'd2);
    repeat (3) step();

    // randomized mix of read bursts and loads
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
          rd(8'($urandom));
          if ($urandom_range(0, 3) == 0) step();
        end
      end else begin
        load_burst(8'($urandom), 9'($urandom_range(1, 12)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom));
      end
    end
    repeat (4) step();
    cmp("rd_drained", 64'(rq.size()), 64'(0));
    for (int i = 0; i < 256; i++)
      if (sram[i] !== ref_mem[i]) cmp("final_mem", 64'(sram[i]), 64'(ref_mem[i]));
    cmp("final_mem_word0", 64'(sram[0]), 64'(ref_mem[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
